// File: rtl/my_bus_pkg.sv
// Shared types and default widths for the MyBus Stage-2 timing scheduler.
package my_bus_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int PEND_W_DEF = 3;

  // Top-level job sequencing states
  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    TX1,
    WAIT2,
    TX2
  } sched_state_e;

  // Per-channel timing states; CH_EXEC is the single execute cycle
  typedef enum logic [1:0] {
    CH_IDLE,
    CH_WAIT,
    CH_EXEC,
    CH_TX
  } chan_state_e;

endpackage

// File: rtl/my_bus_stage2_sched_if.sv
// Stage-1 handshake in, Stage-3/Stage-4 timing strobes out.
// master: the Stage-1/observer side; slave: the scheduler.
interface my_bus_stage2_sched_if;

  logic ready_i;
  logic data_ready_i;
  logic execute1_o;
  logic data_tx1_o;
  logic execute2_o;
  logic data_tx2_o;

  modport master (
    output ready_i,
    output data_ready_i,
    input  execute1_o,
    input  data_tx1_o,
    input  execute2_o,
    input  data_tx2_o
  );

  modport slave (
    input  ready_i,
    input  data_ready_i,
    output execute1_o,
    output data_tx1_o,
    output execute2_o,
    output data_tx2_o
  );

endinterface

// File: rtl/my_bus_stage2_chan.sv
// One timing channel: after start, waits dly cycles, emits a one-cycle execute
// pulse, then a txlen-cycle transmit window. done_o marks the channel's last
// active cycle so the next phase can begin on the following cycle.
module my_bus_stage2_chan
  import my_bus_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] dly_i,
  input  logic [CNT_W-1:0] txlen_i,
  output logic             exec_o,
  output logic             tx_o,
  output logic             done_o
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] txlen_q, txlen_d;
  logic             exec_q, exec_d;
  logic             tx_q, tx_d;

  // Next-state: countdown through wait, execute, transmit; outputs follow next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txlen_d = txlen_q;
    unique case (state_q)
      CH_IDLE: begin
        if (start_i) begin
          txlen_d = txlen_i;
          if (dly_i == '0) begin
            state_d = CH_EXEC;
          end else begin
            state_d = CH_WAIT;
            cnt_d   = dly_i - CNT_W'(1);
          end
        end
      end
      CH_WAIT: begin
        if (cnt_q == '0) state_d = CH_EXEC;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CH_EXEC: begin
        if (txlen_q == '0) begin
          state_d = CH_IDLE;
        end else begin
          state_d = CH_TX;
          cnt_d   = txlen_q - CNT_W'(1);
        end
      end
      CH_TX: begin
        if (cnt_q == '0) state_d = CH_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = CH_IDLE;
    endcase
    if (abort_i) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
    end
    exec_d = (state_d == CH_EXEC);
    tx_d   = (state_d == CH_TX);
  end

  // Channel state, counter and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      txlen_q <= '0;
      exec_q  <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txlen_q <= txlen_d;
      exec_q  <= exec_d;
      tx_q    <= tx_d;
    end
  end

  assign exec_o = exec_q;
  assign tx_o   = tx_q;
  assign done_o = ((state_q == CH_EXEC) && (txlen_q == '0)) ||
                  ((state_q == CH_TX) && (cnt_q == '0));

endmodule

// File: rtl/my_bus_stage2_sched.sv
// MyBus Stage-2 timing scheduler: queues accepted Stage-1 strobes and runs
// one phase-1 (execute1/dataTx1) and optionally phase-2 (execute2/dataTx2)
// timing sequence per job. Optional feature macro: MYBUS_STAGE2_CH2_EN enables
// the second phase; without it jobs end after phase 1 and the Stage-4 strobes
// are held low.
module my_bus_stage2_sched
  import my_bus_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  my_bus_stage2_sched_if.slave bus,
  input  logic [CNT_W-1:0]     cfg_dly1_i,
  input  logic [CNT_W-1:0]     cfg_dly2_i,
  input  logic [CNT_W-1:0]     cfg_txlen_i,
  input  logic                 abort_i,
  input  logic                 clr_ovf_i,
  output logic                 busy_o,
  output logic [PEND_W-1:0]    pending_o,
  output logic                 overflow_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  sched_state_e      state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              accept, start1, ovf_set;
  logic              exec1, tx1, done1;
  logic              exec2, tx2, done2;

  // A job may start only from IDLE with a registered non-zero queue; abort blocks both
  assign accept = bus.ready_i & bus.data_ready_i & ~abort_i;
  assign start1 = (state_q == IDLE) && (pending_q != '0) && !abort_i;

  my_bus_stage2_chan #(.CNT_W(CNT_W)) u_chan1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort_i (abort_i),
    .start_i (start1),
    .dly_i   (cfg_dly1_i),
    .txlen_i (cfg_txlen_i),
    .exec_o  (exec1),
    .tx_o    (tx1),
    .done_o  (done1)
  );

`ifdef MYBUS_STAGE2_CH2_EN
  logic [CNT_W-1:0] dly2_q, dly2_d;
  logic [CNT_W-1:0] txlen2_q, txlen2_d;

  // Phase-2 settings are frozen at job start so mid-job cfg writes hit the next job
  always_comb begin
    dly2_d   = dly2_q;
    txlen2_d = txlen2_q;
    if (start1) begin
      dly2_d   = cfg_dly2_i;
      txlen2_d = cfg_txlen_i;
    end
  end

  // Phase-2 snapshot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly2_q   <= '0;
      txlen2_q <= '0;
    end else begin
      dly2_q   <= dly2_d;
      txlen2_q <= txlen2_d;
    end
  end

  my_bus_stage2_chan #(.CNT_W(CNT_W)) u_chan2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .abort_i (abort_i),
    .start_i (done1),
    .dly_i   (dly2_q),
    .txlen_i (txlen2_q),
    .exec_o  (exec2),
    .tx_o    (tx2),
    .done_o  (done2)
  );
`else
  logic [CNT_W-1:0] unused_dly2;
  assign unused_dly2 = cfg_dly2_i;
  assign exec2 = 1'b0;
  assign tx2   = 1'b0;
  assign done2 = 1'b0;
`endif

  // Job sequencing: follows channel progress, abort forces IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start1) state_d = WAIT1;
`ifdef MYBUS_STAGE2_CH2_EN
      WAIT1: begin
        if (done1)      state_d = WAIT2;
        else if (exec1) state_d = TX1;
      end
      TX1:   if (done1) state_d = WAIT2;
      WAIT2: begin
        if (done2)      state_d = IDLE;
        else if (exec2) state_d = TX2;
      end
      TX2:   if (done2) state_d = IDLE;
`else
      WAIT1: begin
        if (done1)      state_d = IDLE;
        else if (exec1) state_d = TX1;
      end
      TX1:   if (done1) state_d = IDLE;
      WAIT2: state_d = IDLE;
      TX2:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
    busy_d = (state_d != IDLE);
  end

  // Pending count with saturation; sticky overflow where set beats clear
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (abort_i) begin
      pending_d = '0;
    end else if (accept && !start1) begin
      if (pending_q == PEND_MAX) ovf_set   = 1'b1;
      else                       pending_d = pending_q + PEND_W'(1);
    end else if (!accept && start1) begin
      pending_d = pending_q - PEND_W'(1);
    end
    if (ovf_set)        ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.execute1_o = exec1;
  assign bus.data_tx1_o = tx1;
  assign bus.execute2_o = exec2;
  assign bus.data_tx2_o = tx2;
  assign busy_o         = busy_q;
  assign pending_o      = pending_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_my_bus_stage2_sched.sv
// Scoreboard bench for my_bus_stage2_sched: a timestamp-based job model
// predicts each cycle's outputs; a monitor compares them on the falling edge.
module tb_my_bus_stage2_sched;
  import my_bus_pkg::*;

  localparam int CNT_W  = 8;
  localparam int PEND_W = 3;
  localparam int PMAX   = 7;
`ifdef MYBUS_STAGE2_CH2_EN
  localparam bit CH2 = 1'b1;
`else
  localparam bit CH2 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CNT_W-1:0]  cfg_dly1 = '0, cfg_dly2 = '0, cfg_txlen = '0;
  logic              abort = 1'b0, clr_ovf = 1'b0;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  my_bus_stage2_sched_if bus();

  my_bus_stage2_sched #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .cfg_dly1_i  (cfg_dly1),
    .cfg_dly2_i  (cfg_dly2),
    .cfg_txlen_i (cfg_txlen),
    .abort_i     (abort),
    .clr_ovf_i   (clr_ovf),
    .busy_o      (busy),
    .pending_o   (pending),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   last_e1 = -1, last_e2 = -1, last_busy = -1, n_e1 = 0;

  // Reference model: job described by absolute cycle timestamps
  int m_cyc, m_pend;
  bit m_ovf, j_valid;
  int j_t, j_e1, j_tl, j_e2, j_end;

  function automatic logic [8:0] m_out(int n);
    bit on, e1, t1, e2, t2;
    on = j_valid && n >= j_t && n <= j_end;
    e1 = on && n == j_e1;
    t1 = on && n > j_e1 && n <= j_e1 + j_tl;
    e2 = on && CH2 && n == j_e2;
    t2 = on && CH2 && n > j_e2 && n <= j_e2 + j_tl;
    return {e1, t1, e2, t2, on, 3'(m_pend), m_ovf};
  endfunction

  task automatic m_step(input bit rdy, input bit dr, input bit ab, input bit cl);
    bit on, start, acc, set;
    int n;
    n   = m_cyc;
    on  = j_valid && n >= j_t && n <= j_end;
    set = 1'b0;
    if (ab) begin
      m_pend  = 0;
      j_valid = 1'b0;
    end else begin
      start = !on && m_pend > 0;
      acc   = rdy && dr;
      if (acc && !start) begin
        if (m_pend == PMAX) set = 1'b1;
        else                m_pend++;
      end else if (!acc && start) begin
        m_pend--;
      end
      if (start) begin
        j_valid = 1'b1;
        j_t     = n + 1;
        j_e1    = j_t + int'(cfg_dly1);
        j_tl    = int'(cfg_txlen);
        if (CH2) begin
          j_e2  = j_e1 + j_tl + 1 + int'(cfg_dly2);
          j_end = j_e2 + j_tl;
        end else begin
          j_e2  = -10;
          j_end = j_e1 + j_tl;
        end
      end
    end
    if (set)     m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    m_cyc = n + 1;
  endtask

  task automatic push_exp();
    rec_t r;
    r.cyc = m_cyc;
    r.v   = m_out(m_cyc);
    sb.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1: applies inputs for the current cycle, predicts the next
  task automatic drive(input bit rdy, input bit dr, input bit ab, input bit cl);
    bus.ready_i      = rdy;
    bus.data_ready_i = dr;
    abort            = ab;
    clr_ovf          = cl;
    m_step(rdy, dr, ab, cl);
    push_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock
  task automatic do_reset();
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        int'({bus.execute1_o, bus.data_tx1_o, bus.execute2_o, bus.data_tx2_o, busy, pending, ovf}), 0);
    bus.ready_i = 1'b0; bus.data_ready_i = 1'b0; abort = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    m_cyc = 0; m_pend = 0; m_ovf = 1'b0; j_valid = 1'b0;
    j_t = 0; j_e1 = 0; j_tl = 0; j_e2 = 0; j_end = 0;
    last_e1 = -1; last_e2 = -1; last_busy = -1; n_e1 = 0;
    push_exp();
    mon_en = 1'b1;
  endtask

  // Monitor: compares the DUT's outputs with the predicted record every cycle
  initial begin
    rec_t       r;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        act = {bus.execute1_o, bus.data_tx1_o, bus.execute2_o, bus.data_tx2_o, busy, pending, ovf};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: got outputs %b expected a prediction", act);
        end else begin
          r = sb.pop_front();
          if (act !== r.v) begin
            errors++;
            $display("FAIL outputs cyc=%0d: got %b expected %b (e1 t1 e2 t2 busy pend[3] ovf)",
                     r.cyc, act, r.v);
          end
          if (act[8]) begin last_e1 = r.cyc; n_e1++; end
          if (act[6]) last_e2 = r.cyc;
          if (act[4]) last_busy = r.cyc;
        end
      end
    end
  end

  initial begin
    bus.ready_i = 1'b0;
    bus.data_ready_i = 1'b0;
    @(posedge clk);
    #1;

    // Basic two-phase timing
    do_reset();
    cfg_dly1 = 8'd3; cfg_txlen = 8'd2; cfg_dly2 = 8'd1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(15);
    chk("t1_exec1_cycle", last_e1, 5);
    chk("t1_exec2_cycle", last_e2, CH2 ? 9 : -1);
    chk("t1_last_busy", last_busy, CH2 ? 11 : 7);

    // Zero delays, no windows
    do_reset();
    cfg_dly1 = 8'd0; cfg_txlen = 8'd0; cfg_dly2 = 8'd0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);
    chk("t2_exec1_cycle", last_e1, 2);
    chk("t2_exec2_cycle", last_e2, CH2 ? 3 : -1);
    chk("t2_exec1_count", n_e1, 1);

    // Queue overflow, clear, drain
    do_reset();
    cfg_dly1 = 8'd60; cfg_txlen = 8'd5; cfg_dly2 = 8'd1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    cfg_dly1 = 8'd1; cfg_txlen = 8'd1;
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_pending_full", int'(pending), 7);
    chk("t3_overflow_set", int'(ovf), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_overflow_clr", int'(ovf), 0);
    for (int i = 0; i < 1500 && (busy || pending != '0); i++) idle(1);
    idle(2);
    chk("t3_jobs_run", n_e1, 8);

    // Strobes ignored while not ready; accept+start in same cycle
    do_reset();
    cfg_dly1 = 8'd2; cfg_txlen = 8'd1; cfg_dly2 = 8'd0;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_not_ready_pending", int'(pending), 0);
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_accept_and_start", int'(pending), 1);
    chk("t4_busy", int'(busy), 1);
    idle(20);

    // Abort during TX1 with three jobs queued
    do_reset();
    cfg_dly1 = 8'd2; cfg_txlen = 8'd10; cfg_dly2 = 8'd2;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_pending_before_abort", int'(pending), 3);
    chk("t5_in_tx1", int'(bus.data_tx1_o), 1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_abort_pending", int'(pending), 0);
    chk("t5_abort_tx1", int'(bus.data_tx1_o), 0);
    chk("t5_abort_busy", int'(busy), 0);
    idle(4);

    // Reset in the middle of a job (phase 2 wait when enabled)
    do_reset();
    cfg_dly1 = 8'd1; cfg_txlen = 8'd2; cfg_dly2 = 8'd20;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(9);
    do_reset();
    idle(3);

    // Randomized traffic with cfg churn, aborts and clears
    for (int i = 0; i < 2500; i++) begin
      if (i == 1300) do_reset();
      cfg_dly1  = 8'($urandom_range(0, 4));
      cfg_dly2  = 8'($urandom_range(0, 4));
      cfg_txlen = 8'($urandom_range(0, 3));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
